seg_reg: RTL and testbench

- Generic pipeline segment register (IF/ID, ID/EX, EX/MEM, MEM/WB) that consumes the stall/flush strobes produced by the pipeline hazard controller.
- Captures one stage's payload per cycle.
- Holds the payload on stall; replaces it with a bubble on flush.
- Tracks slot occupancy, with an optional per-segment stall/flush/bubble statistics block.

---
 rtl/seg_reg.sv | 130 +++++++++++++
 tb/tb_seg_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_reg.sv
// seg_reg: generic pipeline segment register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Each cycle it either captures one stage's payload, holds it on stall, or
// replaces it with a bubble on flush. Slot occupancy is tracked by a small FSM
// (S_EMPTY / S_RUN / S_HOLD), and a saturating counter records how long the
// current occupant has been stalled.
// Optional statistics (stall/flush/bubble cycle counters) are compiled in when
// the macro SEG_REG_PERF_EN is defined.
module seg_reg #(
  parameter int          DATA_W   = 128,
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [31:0]       inst_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [31:0]       inst_out,
  output logic [DATA_W-1:0] data_out,
  output logic              held,
  output logic [HOLD_W-1:0] hold_cnt
`ifdef SEG_REG_PERF_EN
  ,
  output logic [31:0]       stall_cyc,
  output logic [31:0]       flush_cyc,
  output logic [31:0]       bubble_cyc
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_RUN   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_MAX = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t state_reg;

  // Slot FSM with registered payload and status outputs.
  // Priority: reset, then debug halt (en=0 freezes everything), flush, stall, load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_EMPTY;
      valid_out <= 1'b0;
      pc_out    <= '0;
      inst_out  <= NOP_INST;
      data_out  <= '0;
      held      <= 1'b0;
      hold_cnt  <= '0;
    end else if (en) begin
      if (flush) begin
        // Bubble: flush beats a coincident stall (branch redirect over load-use).
        state_reg <= S_EMPTY;
        valid_out <= 1'b0;
        pc_out    <= '0;
        inst_out  <= NOP_INST;
        data_out  <= '0;
        held      <= 1'b0;
        hold_cnt  <= '0;
      end else if (stall) begin
        // Payload holds; only an occupied slot counts stall cycles.
        if (state_reg != S_EMPTY) begin
          state_reg <= S_HOLD;
          held      <= 1'b1;
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
      end else begin
        valid_out <= valid_in;
        pc_out    <= pc_in;
        held      <= 1'b0;
        hold_cnt  <= '0;
        if (valid_in) begin
          state_reg <= S_RUN;
          inst_out  <= inst_in;
          data_out  <= data_in;
        end else begin
          // Invalid slots are scrubbed so they never carry side-effect controls.
          state_reg <= S_EMPTY;
          inst_out  <= NOP_INST;
          data_out  <= '0;
        end
      end
    end
  end

`ifdef SEG_REG_PERF_EN
  logic valid_next;

  // Slot validity that the FSM will present after the coming edge.
  always_comb begin
    valid_next = valid_in;
    if (flush) begin
      valid_next = 1'b0;
    end else if (stall) begin
      valid_next = valid_out;
    end
  end

  // Statistics counters; wrap modulo 2^32 and freeze during debug halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc  <= '0;
      flush_cyc  <= '0;
      bubble_cyc <= '0;
    end else if (en) begin
      if (stall && !flush) begin
        stall_cyc <= stall_cyc + 32'd1;
      end
      if (flush) begin
        flush_cyc <= flush_cyc + 32'd1;
      end
      if (!valid_next) begin
        bubble_cyc <= bubble_cyc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seg_reg.sv
// Self-checking bench for seg_reg: a behavioural slot model is compared with
// the DUT on every falling edge, and directed scenarios add literal checks.
module tb_seg_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, stall, flush, valid_in;
  logic [31:0]  pc_in, inst_in;
  logic [127:0] data_in;
  logic         valid_out, held;
  logic [31:0]  pc_out, inst_out;
  logic [127:0] data_out;
  logic [3:0]   hold_cnt;
`ifdef SEG_REG_PERF_EN
  logic [31:0]  stall_cyc, flush_cyc, bubble_cyc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_reg dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .stall     (stall),
    .flush     (flush),
    .valid_in  (valid_in),
    .pc_in     (pc_in),
    .inst_in   (inst_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .data_out  (data_out),
    .held      (held),
    .hold_cnt  (hold_cnt)
`ifdef SEG_REG_PERF_EN
    ,
    .stall_cyc (stall_cyc),
    .flush_cyc (flush_cyc),
    .bubble_cyc(bubble_cyc)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the slot must contain, from the rules directly.
  logic         m_valid, m_held;
  logic [31:0]  m_pc, m_inst;
  logic [127:0] m_data;
  int           m_cnt;
  logic [31:0]  m_stall, m_flush, m_bubble;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_held <= 1'b0; m_pc <= 0; m_inst <= NOP; m_data <= 0; m_cnt <= 0;
      m_stall <= 0; m_flush <= 0; m_bubble <= 0;
    end else if (en) begin
      if (flush) begin
        m_valid <= 1'b0; m_held <= 1'b0; m_pc <= 0; m_inst <= NOP; m_data <= 0; m_cnt <= 0;
        m_flush <= m_flush + 1;
        m_bubble <= m_bubble + 1;
      end else if (stall) begin
        m_stall <= m_stall + 1;
        if (!m_valid) m_bubble <= m_bubble + 1;
        if (m_valid) begin
          m_held <= 1'b1;
          m_cnt  <= (m_cnt < 15) ? m_cnt + 1 : 15;
        end
      end else begin
        m_valid <= valid_in;
        m_held  <= 1'b0;
        m_pc    <= pc_in;
        m_inst  <= valid_in ? inst_in : NOP;
        m_data  <= valid_in ? data_in : 128'd0;
        m_cnt   <= 0;
        if (!valid_in) m_bubble <= m_bubble + 1;
      end
    end
  end

  // Compare DUT against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_out", 128'(valid_out), 128'(m_valid));
      chk("pc_out",    128'(pc_out),    128'(m_pc));
      chk("inst_out",  128'(inst_out),  128'(m_inst));
      chk("data_out",  data_out,        m_data);
      chk("held",      128'(held),      128'(m_held));
      chk("hold_cnt",  128'(hold_cnt),  128'(m_cnt));
`ifdef SEG_REG_PERF_EN
      chk("stall_cyc",  128'(stall_cyc),  128'(m_stall));
      chk("flush_cyc",  128'(flush_cyc),  128'(m_flush));
      chk("bubble_cyc", 128'(bubble_cyc), 128'(m_bubble));
`endif
    end
  end

  // Apply one cycle of inputs, let the edge take them, land 1 time unit after it.
  task automatic drive(input logic e, input logic s, input logic f, input logic v,
                       input logic [31:0] pc, input logic [31:0] inst, input logic [127:0] d);
    en = e; stall = s; flush = f; valid_in = v; pc_in = pc; inst_in = inst; data_in = d;
    @(posedge clk);
    #1;
    $display("cyc en=%0b stall=%0b flush=%0b vin=%0b pc_in=%h -> v=%0b pc=%h inst=%h held=%0b cnt=%0d",
             e, s, f, v, pc, v, pc_out, inst_out, held, hold_cnt);
  endtask

  logic [31:0] snap_pc;
  logic [31:0] base_stall;

  initial begin
    rst = 1'b1; en = 1'b1; stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    pc_in = 0; inst_in = 0; data_in = 0;
    #12 rst = 1'b0;
    chk("rst_valid", 128'(valid_out), 128'd0);
    chk("rst_inst",  128'(inst_out),  128'(NOP));
    chk("rst_cnt",   128'(hold_cnt),  128'd0);

    // Reset mid-operation, asserted between edges.
    drive(1, 0, 0, 1, 32'h100, 32'h00100093, 128'h11);
    chk("load_pc100", 128'(pc_out), 128'h100);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 128'(valid_out), 128'd0);
    chk("async_rst_inst",  128'(inst_out),  128'(NOP));
    chk("async_rst_cnt",   128'(hold_cnt),  128'd0);
    chk("async_rst_pc",    128'(pc_out),    128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Normal flow.
    drive(1, 0, 0, 1, 32'h200, 32'h00A00093, 128'hABCD);
    chk("nf_valid", 128'(valid_out), 128'd1);
    chk("nf_pc",    128'(pc_out),    128'h200);
    chk("nf_inst",  128'(inst_out),  128'h00A00093);
    chk("nf_held",  128'(held),      128'd0);

    // Load-use stall for 3 cycles, then release.
    drive(1, 0, 0, 1, 32'h204, 32'h00B00113, 128'h22);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0, 1, 32'h900 + i, 32'hDEAD0000 + i, 128'h99);
      chk("stall_pc",   128'(pc_out),   128'h204);
      chk("stall_held", 128'(held),     128'd1);
      chk("stall_cnt",  128'(hold_cnt), 128'(i));
    end
    drive(1, 0, 0, 1, 32'h208, 32'h00C00193, 128'h33);
    chk("release_pc",  128'(pc_out),   128'h208);
    chk("release_cnt", 128'(hold_cnt), 128'd0);

    // Stall once, then stall+flush together: flush wins.
    drive(1, 1, 0, 1, 32'h20C, 32'h1, 128'h1);
    chk("hold208_held", 128'(held), 128'd1);
    base_stall = m_stall;
    drive(1, 1, 1, 1, 32'h210, 32'h2, 128'h2);
    chk("sf_valid", 128'(valid_out), 128'd0);
    chk("sf_inst",  128'(inst_out),  128'(NOP));
    chk("sf_data",  data_out,        128'd0);
    chk("sf_cnt",   128'(hold_cnt),  128'd0);
`ifdef SEG_REG_PERF_EN
    chk("sf_stall_unchanged", 128'(stall_cyc), 128'(base_stall));
`endif

    // Debug halt with flush and new inputs: nothing moves.
    drive(1, 0, 0, 1, 32'h300, 32'h00D00213, 128'h44);
    snap_pc = 32'h300;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1, 32'h500 + i, 32'h5, 128'h55);
      chk("halt_pc",    128'(pc_out),    128'(snap_pc));
      chk("halt_valid", 128'(valid_out), 128'd1);
    end
    drive(1, 0, 1, 1, 32'h600, 32'h6, 128'h66);
    chk("halt_flush_valid", 128'(valid_out), 128'd0);
    chk("halt_flush_inst",  128'(inst_out),  128'(NOP));

    // Saturation of the hold counter.
    drive(1, 0, 0, 1, 32'h400, 32'h00E00293, 128'h77);
    base_stall = m_stall;
    for (int i = 1; i <= 20; i++) begin
      drive(1, 1, 0, 0, 32'h0, 32'h0, 128'h0);
      chk("sat_cnt", 128'(hold_cnt), 128'((i < 15) ? i : 15));
    end
    chk("sat_pc", 128'(pc_out), 128'h400);
`ifdef SEG_REG_PERF_EN
    chk("sat_stall_cyc", 128'(stall_cyc - base_stall), 128'd20);
`endif

    // Invalid load scrubs inst/data; stall on an empty slot keeps count at 0.
    drive(1, 0, 0, 0, 32'h700, 32'hFFFFFFFF, 128'hFF);
    chk("inv_valid", 128'(valid_out), 128'd0);
    chk("inv_inst",  128'(inst_out),  128'(NOP));
    chk("inv_data",  data_out,        128'd0);
    chk("inv_pc",    128'(pc_out),    128'h700);
    drive(1, 1, 0, 1, 32'h800, 32'h8, 128'h8);
    chk("empty_stall_cnt",  128'(hold_cnt), 128'd0);
    chk("empty_stall_held", 128'(held),     128'd0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
